// File: rtl/wb_interconnect_tgt_port.sv
`default_nettype none
// ============================================================================
// Module   : wb_interconnect_tgt_port
// Purpose  : Target-side port stage of the Wishbone interconnect. It consumes
//            the arbiter's one-hot grant and forwards the granted initiator's
//            request to one target. It returns the target's ack/err and read
//            data to that initiator, and pulses arb_ack so the arbiter can
//            release the grant. A bus timeout turns a hung target into an
//            error response.
// Ports    : clock, reset         - clock, asynchronous active-high reset
//            gnt                  - one-hot grant from arbiter (lowest bit wins)
//            arb_ack              - one-cycle completion pulse to arbiter
//            i_adr/i_dat_w/i_sel  - packed initiator request fields
//            i_we/i_cyc/i_stb     - per-initiator control
//            i_dat_r              - read data broadcast to all initiators
//            i_ack/i_err          - per-initiator response pulses
//            t_adr/t_dat_w/t_sel  - target request fields
//            t_we/t_cyc/t_stb     - target control
//            t_dat_r/t_ack/t_err  - target response
// Revision : 1.0 - initial release
// ============================================================================
module wb_interconnect_tgt_port #(
  parameter int N_INIT     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_INIT-1:0]               gnt,
  output logic                            arb_ack,
  input  logic [N_INIT*ADDR_WIDTH-1:0]    i_adr,
  input  logic [N_INIT*DATA_WIDTH-1:0]    i_dat_w,
  input  logic [N_INIT*(DATA_WIDTH/8)-1:0] i_sel,
  input  logic [N_INIT-1:0]               i_we,
  input  logic [N_INIT-1:0]               i_cyc,
  input  logic [N_INIT-1:0]               i_stb,
  output logic [DATA_WIDTH-1:0]           i_dat_r,
  output logic [N_INIT-1:0]               i_ack,
  output logic [N_INIT-1:0]               i_err,
  output logic [ADDR_WIDTH-1:0]           t_adr,
  output logic [DATA_WIDTH-1:0]           t_dat_w,
  output logic [DATA_WIDTH/8-1:0]         t_sel,
  output logic                            t_we,
  output logic                            t_cyc,
  output logic                            t_stb,
  input  logic [DATA_WIDTH-1:0]           t_dat_r,
  input  logic                            t_ack,
  input  logic                            t_err
);

  localparam int c_sel_w = DATA_WIDTH / 8;
  localparam int c_idx_w = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_cnt_w-1:0]    r_cnt;

  logic [ADDR_WIDTH-1:0] w_adr_arr   [N_INIT];
  logic [DATA_WIDTH-1:0] w_dat_w_arr [N_INIT];
  logic [c_sel_w-1:0]    w_sel_arr   [N_INIT];

  logic [c_idx_w-1:0]    w_sel_idx;
  logic                  w_req;
  logic                  w_cur_cyc;
  logic                  w_tmo;
  logic [N_INIT-1:0]     w_idx_oh;

  // Unpack the flat initiator buses so the request can be muxed by index.
  generate
    for (genvar k = 0; k < N_INIT; k++) begin : g_unpack
      assign w_adr_arr[k]   = i_adr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_dat_w_arr[k] = i_dat_w[k*DATA_WIDTH +: DATA_WIDTH];
      assign w_sel_arr[k]   = i_sel[k*c_sel_w +: c_sel_w];
    end
  endgenerate

  // Lowest set grant bit wins, so a malformed multi-hot grant still picks
  // exactly one initiator.
  always_comb begin
    w_sel_idx = '0;
    for (int k = N_INIT - 1; k >= 0; k--) begin
      if (gnt[k]) begin
        w_sel_idx = c_idx_w'(k);
      end
    end
  end

  assign w_req     = (|gnt) & i_cyc[w_sel_idx] & i_stb[w_sel_idx];
  assign w_cur_cyc = i_cyc[r_idx];

  always_comb begin
    w_idx_oh        = '0;
    w_idx_oh[r_idx] = 1'b1;
  end

  // The counter starts at 0 in the first BUSY cycle, so matching TIMEOUT-1
  // fires the error response TIMEOUT cycles after t_stb rose.
  generate
    if (TIMEOUT > 0) begin : g_tmo_on
      assign w_tmo = (r_cnt == c_cnt_w'(TIMEOUT - 1));
    end else begin : g_tmo_off
      assign w_tmo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      arb_ack <= 1'b0;
      i_dat_r <= '0;
      i_ack   <= '0;
      i_err   <= '0;
      t_adr   <= '0;
      t_dat_w <= '0;
      t_sel   <= '0;
      t_we    <= 1'b0;
      t_cyc   <= 1'b0;
      t_stb   <= 1'b0;
    end else begin
      // Response strobes are single-cycle by construction.
      arb_ack <= 1'b0;
      i_ack   <= '0;
      i_err   <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_idx   <= w_sel_idx;
            t_adr   <= w_adr_arr[w_sel_idx];
            t_dat_w <= w_dat_w_arr[w_sel_idx];
            t_sel   <= w_sel_arr[w_sel_idx];
            t_we    <= i_we[w_sel_idx];
            t_cyc   <= 1'b1;
            t_stb   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // A real target response beats both the abort and the timeout;
          // err beats ack when a target drives both.
          if (t_err) begin
            i_err   <= w_idx_oh;
            arb_ack <= 1'b1;
            t_cyc   <= 1'b0;
            t_stb   <= 1'b0;
            r_state <= ST_DONE;
          end else if (t_ack) begin
            i_dat_r <= t_dat_r;
            i_ack   <= w_idx_oh;
            arb_ack <= 1'b1;
            t_cyc   <= 1'b0;
            t_stb   <= 1'b0;
            r_state <= ST_DONE;
          end else if (!w_cur_cyc) begin
            // Initiator walked away: release the target and the grant silently.
            arb_ack <= 1'b1;
            t_cyc   <= 1'b0;
            t_stb   <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_tmo) begin
            i_err   <= w_idx_oh;
            arb_ack <= 1'b1;
            t_cyc   <= 1'b0;
            t_stb   <= 1'b0;
            r_state <= ST_DONE;
          end
        end

        // One dead cycle while the arbiter drops the grant, so the stale
        // grant is never sampled again in IDLE.
        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_interconnect_tgt_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_interconnect_tgt_port
// Purpose  : Directed self-checking bench for wb_interconnect_tgt_port. One
//            instance runs with TIMEOUT=8 and a second one with TIMEOUT=0
//            shares the same stimulus. A small round-robin arbiter and a
//            zero-wait target can be switched in for back-to-back traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_interconnect_tgt_port;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;

  logic [N-1:0]    gnt_drv;
  logic [N-1:0]    arb_gnt;
  logic [N-1:0]    gnt;
  logic            use_arb;
  logic            auto_ack;
  logic            arb_last;

  logic [N*AW-1:0] i_adr;
  logic [N*DW-1:0] i_dat_w;
  logic [N*SW-1:0] i_sel;
  logic [N-1:0]    i_we;
  logic [N-1:0]    i_cyc;
  logic [N-1:0]    i_stb;
  logic [DW-1:0]   t_dat_r;
  logic            t_ack_drv;
  logic            t_ack;
  logic            t_err;

  logic            arb_ack;
  logic [DW-1:0]   i_dat_r;
  logic [N-1:0]    i_ack;
  logic [N-1:0]    i_err;
  logic [AW-1:0]   t_adr;
  logic [DW-1:0]   t_dat_w;
  logic [SW-1:0]   t_sel;
  logic            t_we;
  logic            t_cyc;
  logic            t_stb;

  logic            z_arb_ack;
  logic [DW-1:0]   z_i_dat_r;
  logic [N-1:0]    z_i_ack;
  logic [N-1:0]    z_i_err;
  logic [AW-1:0]   z_t_adr;
  logic [DW-1:0]   z_t_dat_w;
  logic [SW-1:0]   z_t_sel;
  logic            z_t_we;
  logic            z_t_cyc;
  logic            z_t_stb;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign gnt   = use_arb ? arb_gnt : gnt_drv;
  assign t_ack = auto_ack ? t_stb : t_ack_drv;

  // Round-robin arbiter: releases the grant the cycle after arb_ack and
  // regrants one cycle later.
  always @(posedge clock) begin
    if (!use_arb) begin
      arb_gnt  <= '0;
      arb_last <= 1'b1;
    end else if (arb_ack) begin
      arb_gnt <= '0;
    end else if (arb_gnt == '0) begin
      if (!arb_last && i_cyc[1] && i_stb[1]) begin
        arb_gnt  <= 2'b10;
        arb_last <= 1'b1;
      end else if (i_cyc[0] && i_stb[0]) begin
        arb_gnt  <= 2'b01;
        arb_last <= 1'b0;
      end else if (i_cyc[1] && i_stb[1]) begin
        arb_gnt  <= 2'b10;
        arb_last <= 1'b1;
      end
    end
  end

  wb_interconnect_tgt_port #(
    .N_INIT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .gnt(gnt), .arb_ack(arb_ack),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack),
    .i_err(i_err), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_sel(t_sel),
    .t_we(t_we), .t_cyc(t_cyc), .t_stb(t_stb), .t_dat_r(t_dat_r),
    .t_ack(t_ack), .t_err(t_err)
  );

  wb_interconnect_tgt_port #(
    .N_INIT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)
  ) dut0 (
    .clock(clock), .reset(reset), .gnt(gnt), .arb_ack(z_arb_ack),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(z_i_dat_r), .i_ack(z_i_ack),
    .i_err(z_i_err), .t_adr(z_t_adr), .t_dat_w(z_t_dat_w), .t_sel(z_t_sel),
    .t_we(z_t_we), .t_cyc(z_t_cyc), .t_stb(z_t_stb), .t_dat_r(t_dat_r),
    .t_ack(t_ack), .t_err(t_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    gnt_drv   = '0;
    i_adr     = '0;
    i_dat_w   = '0;
    i_sel     = '0;
    i_we      = '0;
    i_cyc     = '0;
    i_stb     = '0;
    t_dat_r   = '0;
    t_ack_drv = 1'b0;
    t_err     = 1'b0;
  endtask

  task automatic test_reset();
    use_arb  = 1'b0;
    auto_ack = 1'b0;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({t_cyc, t_stb, t_we, arb_ack, i_ack, i_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {t_cyc, t_stb, t_we, arb_ack, i_ack, i_err});
    end
    checks++;
    if ({t_adr, t_dat_w, t_sel, i_dat_r} !== '0) begin
      errors++;
      $display("FAIL reset_data: t_adr=%h t_dat_w=%h t_sel=%h i_dat_r=%h required 0", t_adr, t_dat_w, t_sel, i_dat_r);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    i_adr[AW +: AW] = 32'h0000_0100;
    i_we[1]  = 1'b0;
    i_cyc[1] = 1'b1;
    i_stb[1] = 1'b1;
    gnt_drv  = 2'b10;
    tick();
    checks++;
    if (t_adr !== 32'h100 || {t_cyc, t_stb, t_we} !== 3'b110) begin
      errors++;
      $display("FAIL read_req: t_adr=%h cyc/stb/we=%b required 100/110", t_adr, {t_cyc, t_stb, t_we});
    end
    // initiator fields change mid-transfer; target side must stay frozen
    i_adr[AW +: AW] = 32'h0BAD_0BAD;
    tick();
    tick();
    checks++;
    if (t_adr !== 32'h100 || t_cyc !== 1'b1 || i_ack !== 2'b00) begin
      errors++;
      $display("FAIL read_hold: t_adr=%h t_cyc=%b i_ack=%b required 100/1/00", t_adr, t_cyc, i_ack);
    end
    t_ack_drv = 1'b1;
    t_dat_r   = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (i_ack !== 2'b10 || i_dat_r !== 32'hDEAD_BEEF || arb_ack !== 1'b1 || t_cyc !== 1'b0 || i_err !== 2'b00) begin
      errors++;
      $display("FAIL read_ack: i_ack=%b i_dat_r=%h arb_ack=%b t_cyc=%b i_err=%b required 10/deadbeef/1/0/00",
               i_ack, i_dat_r, arb_ack, t_cyc, i_err);
    end
    t_ack_drv = 1'b0;
    t_dat_r   = '0;
    gnt_drv   = '0;
    i_cyc     = '0;
    i_stb     = '0;
    tick();
    checks++;
    if (i_ack !== 2'b00 || arb_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse: i_ack=%b arb_ack=%b required 00/0", i_ack, arb_ack);
    end
    tick();
  endtask

  task automatic test_write();
    i_adr[0 +: AW]   = 32'h0000_0040;
    i_dat_w[0 +: DW] = 32'h1234_5678;
    i_sel[0 +: SW]   = 4'b0011;
    i_we[0]  = 1'b1;
    i_cyc[0] = 1'b1;
    i_stb[0] = 1'b1;
    gnt_drv  = 2'b01;
    tick();
    checks++;
    if (t_adr !== 32'h40 || t_dat_w !== 32'h1234_5678 || t_sel !== 4'b0011 || t_we !== 1'b1 || t_cyc !== 1'b1) begin
      errors++;
      $display("FAIL write_req: t_adr=%h t_dat_w=%h t_sel=%b t_we=%b t_cyc=%b required 40/12345678/0011/1/1",
               t_adr, t_dat_w, t_sel, t_we, t_cyc);
    end
    t_ack_drv = 1'b1;
    t_dat_r   = 32'h55AA_55AA;
    tick();
    checks++;
    if (i_ack !== 2'b01 || arb_ack !== 1'b1 || t_cyc !== 1'b0 || i_dat_r !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL write_ack: i_ack=%b arb_ack=%b t_cyc=%b i_dat_r=%h required 01/1/0/55aa55aa",
               i_ack, arb_ack, t_cyc, i_dat_r);
    end
    t_ack_drv = 1'b0;
    gnt_drv   = '0;
    i_cyc     = '0;
    i_stb     = '0;
    i_we      = '0;
    tick();
    checks++;
    if (i_ack !== 2'b00) begin
      errors++;
      $display("FAIL write_pulse: i_ack=%b required 00", i_ack);
    end
    tick();
  endtask

  task automatic test_target_error();
    i_cyc[0] = 1'b1;
    i_stb[0] = 1'b1;
    gnt_drv  = 2'b01;
    tick();
    t_ack_drv = 1'b1;
    t_err     = 1'b1;
    t_dat_r   = 32'hCAFE_F00D;
    tick();
    checks++;
    if (i_err !== 2'b01 || i_ack !== 2'b00 || arb_ack !== 1'b1 || t_cyc !== 1'b0) begin
      errors++;
      $display("FAIL err_resp: i_err=%b i_ack=%b arb_ack=%b t_cyc=%b required 01/00/1/0", i_err, i_ack, arb_ack, t_cyc);
    end
    checks++;
    if (i_dat_r !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL err_data: i_dat_r=%h required 55aa55aa", i_dat_r);
    end
    t_ack_drv = 1'b0;
    t_err     = 1'b0;
    gnt_drv   = '0;
    i_cyc     = '0;
    i_stb     = '0;
    tick();
    checks++;
    if (i_err !== 2'b00 || arb_ack !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: i_err=%b arb_ack=%b required 00/0", i_err, arb_ack);
    end
    tick();
  endtask

  task automatic test_timeout();
    i_adr[AW +: AW] = 32'h0000_0200;
    i_cyc[1] = 1'b1;
    i_stb[1] = 1'b1;
    gnt_drv  = 2'b10;
    tick();
    checks++;
    if (t_stb !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start: t_stb=%b required 1", t_stb);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (t_cyc !== 1'b1 || i_err !== 2'b00) begin
        errors++;
        $display("FAIL tmo_wait: cycle %0d t_cyc=%b i_err=%b required 1/00", i, t_cyc, i_err);
      end
    end
    tick();
    checks++;
    if (i_err !== 2'b10 || arb_ack !== 1'b1 || t_cyc !== 1'b0 || i_ack !== 2'b00) begin
      errors++;
      $display("FAIL tmo_fire: i_err=%b arb_ack=%b t_cyc=%b i_ack=%b required 10/1/0/00", i_err, arb_ack, t_cyc, i_ack);
    end
    // keep initiator 1 in its cycle so the TIMEOUT=0 instance stays busy
    gnt_drv = '0;
    tick();
    checks++;
    if (i_err !== 2'b00 || t_cyc !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: i_err=%b t_cyc=%b required 00/0", i_err, t_cyc);
    end
  endtask

  task automatic test_timeout_disabled();
    for (int i = 0; i < 1000; i++) begin
      tick();
      checks++;
      if (z_t_cyc !== 1'b1 || z_i_err !== 2'b00 || z_arb_ack !== 1'b0) begin
        errors++;
        $display("FAIL notmo_hold: cycle %0d t_cyc=%b i_err=%b arb_ack=%b required 1/00/0", i, z_t_cyc, z_i_err, z_arb_ack);
      end
    end
    i_cyc = '0;
    i_stb = '0;
    tick();
    checks++;
    if (z_t_cyc !== 1'b0 || z_arb_ack !== 1'b1 || z_i_err !== 2'b00 || z_i_ack !== 2'b00) begin
      errors++;
      $display("FAIL notmo_release: t_cyc=%b arb_ack=%b i_err=%b i_ack=%b required 0/1/00/00",
               z_t_cyc, z_arb_ack, z_i_err, z_i_ack);
    end
    tick();
    tick();
  endtask

  task automatic test_abort();
    i_cyc[1] = 1'b1;
    i_stb[1] = 1'b1;
    gnt_drv  = 2'b10;
    tick();
    tick();
    tick();
    i_cyc[1] = 1'b0;
    i_stb[1] = 1'b0;
    tick();
    checks++;
    if (t_cyc !== 1'b0 || t_stb !== 1'b0 || arb_ack !== 1'b1 || i_ack !== 2'b00 || i_err !== 2'b00) begin
      errors++;
      $display("FAIL abort: t_cyc=%b t_stb=%b arb_ack=%b i_ack=%b i_err=%b required 0/0/1/00/00",
               t_cyc, t_stb, arb_ack, i_ack, i_err);
    end
    gnt_drv = '0;
    tick();
    checks++;
    if (arb_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: arb_ack=%b required 0", arb_ack);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ack_val [4];
    int           ack_cyc [4];
    logic [N-1:0] exp_val [4];
    int           n = 0;
    exp_val[0] = 2'b01;
    exp_val[1] = 2'b10;
    exp_val[2] = 2'b01;
    exp_val[3] = 2'b10;
    i_adr[0 +: AW]  = 32'h0000_1000;
    i_adr[AW +: AW] = 32'h0000_2000;
    i_cyc    = 2'b11;
    i_stb    = 2'b11;
    t_dat_r  = 32'h1357_9BDF;
    use_arb  = 1'b1;
    auto_ack = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (i_ack !== 2'b00 && n < 4) begin
        ack_val[n] = i_ack;
        ack_cyc[n] = c;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL b2b_count: saw %0d acks within 60 cycles required 4", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (ack_val[k] !== exp_val[k]) begin
        errors++;
        $display("FAIL b2b_target: ack %0d i_ack=%b required %b", k, ack_val[k], exp_val[k]);
      end
      if (k > 0) begin
        checks++;
        if (ack_cyc[k] - ack_cyc[k-1] != 4) begin
          errors++;
          $display("FAIL b2b_spacing: ack %0d spacing %0d required 4", k, ack_cyc[k] - ack_cyc[k-1]);
        end
      end
    end
    use_arb  = 1'b0;
    auto_ack = 1'b0;
    i_cyc    = '0;
    i_stb    = '0;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    i_adr[0 +: AW]   = 32'h0000_0040;
    i_dat_w[0 +: DW] = 32'hA5A5_A5A5;
    i_sel[0 +: SW]   = 4'b1111;
    i_we[0]  = 1'b1;
    i_cyc[0] = 1'b1;
    i_stb[0] = 1'b1;
    gnt_drv  = 2'b01;
    tick();
    checks++;
    if (t_cyc !== 1'b1 || i_dat_r === '0) begin
      errors++;
      $display("FAIL arst_pre: t_cyc=%b i_dat_r=%h required 1/nonzero", t_cyc, i_dat_r);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({t_cyc, t_stb, t_we, arb_ack, i_ack, i_err} !== 7'd0 || {t_adr, t_dat_w, t_sel, i_dat_r} !== '0) begin
      errors++;
      $display("FAIL arst_clear: ctrl=%b t_adr=%h t_dat_w=%h t_sel=%b i_dat_r=%h required all 0",
               {t_cyc, t_stb, t_we, arb_ack, i_ack, i_err}, t_adr, t_dat_w, t_sel, i_dat_r);
    end
    checks++;
    if ({z_t_cyc, z_t_stb, z_t_we, z_arb_ack, z_i_ack, z_i_err} !== 7'd0 ||
        {z_t_adr, z_t_dat_w, z_t_sel, z_i_dat_r} !== '0) begin
      errors++;
      $display("FAIL arst_clear_t0: ctrl=%b t_adr=%h t_dat_w=%h t_sel=%b i_dat_r=%h required all 0",
               {z_t_cyc, z_t_stb, z_t_we, z_arb_ack, z_i_ack, z_i_err}, z_t_adr, z_t_dat_w, z_t_sel, z_i_dat_r);
    end
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (i_ack !== 2'b00 || i_err !== 2'b00 || t_cyc !== 1'b0 || arb_ack !== 1'b0) begin
      errors++;
      $display("FAIL arst_after: i_ack=%b i_err=%b t_cyc=%b arb_ack=%b required 00/00/0/0", i_ack, i_err, t_cyc, arb_ack);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_target_error();
    test_timeout();
    test_timeout_disabled();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/wb_interconnect_tgt_port.md
Name: wb_interconnect_tgt_port

Overview:
Target-side port stage that consumes the one-hot grant vector produced by the interconnect arbiter. It routes the granted initiator's Wishbone request to a single target and returns the target's ack/err and read data to that initiator. It also produces the completion pulse the arbiter uses to release the grant. A bus timeout converts a hung target into an error response.

Parameters:
N_INIT, 2, number of initiators (width of grant vector), >=1
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width (multiple of 8)
TIMEOUT, 256, cycles in BUSY before forced error; 0 disables timeout

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
gnt  in  N_INIT  one-hot grant from arbiter
arb_ack  out  1  one-cycle completion pulse to arbiter
i_adr  in  N_INIT*ADDR_WIDTH  initiator addresses, initiator k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_dat_w  in  N_INIT*DATA_WIDTH  initiator write data
i_sel  in  N_INIT*(DATA_WIDTH/8)  initiator byte selects
i_we  in  N_INIT  initiator write enables
i_cyc  in  N_INIT  initiator cycle
i_stb  in  N_INIT  initiator strobe
i_dat_r  out  DATA_WIDTH  read data, broadcast to all initiators
i_ack  out  N_INIT  per-initiator ack
i_err  out  N_INIT  per-initiator err
t_adr  out  ADDR_WIDTH  target address
t_dat_w  out  DATA_WIDTH  target write data
t_sel  out  DATA_WIDTH/8  target byte select
t_we  out  1  target write enable
t_cyc  out  1  target cycle
t_stb  out  1  target strobe
t_dat_r  in  DATA_WIDTH  target read data
t_ack  in  1  target ack
t_err  in  1  target err

Behaviour:
- Reset, asynchronous: state=IDLE, sel index=0, timeout counter=0. All outputs are 0: t_*, i_dat_r, i_ack, i_err, arb_ack.
- All outputs are registered. No combinational path from gnt or t_ack/t_err to any output.
- Index selection: lowest set bit of gnt. Non-one-hot gnt is tolerated, and the lowest bit wins.
- IDLE:
  - Condition: gnt!=0 and the selected initiator has i_cyc&i_stb.
  - Action: latch the index; capture that initiator's adr/dat_w/sel/we into t_*; set t_cyc=t_stb=1; clear the counter; go to BUSY.
  - Target sees the request the cycle after gnt rises.
  - If gnt!=0 but the selected cyc&stb is low, stay in IDLE.
- BUSY (t_* held stable; the counter increments each cycle):
  - t_ack sampled: i_dat_r<=t_dat_r, i_ack[idx]<=1, arb_ack<=1, t_cyc/t_stb<=0, go to DONE.
  - t_err sampled: same as t_ack but i_err[idx]<=1 instead of i_ack; i_dat_r is unchanged.
  - t_ack and t_err together: err wins; i_ack stays 0.
  - Timeout: TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack/err. Result is i_err[idx]<=1, arb_ack<=1, t_cyc/t_stb<=0, go to DONE.
  - Abort: the latched initiator's i_cyc drops. Result is t_cyc/t_stb<=0, arb_ack<=1, no i_ack/i_err, go to DONE.
  - A response sampled in the same cycle as the abort takes priority over the abort.
- DONE (exactly one cycle):
  - arb_ack, i_ack and i_err return to 0 next cycle; go to IDLE.
  - This covers the arbiter's one-cycle gnt release latency, so the stale gnt is never re-serviced.
- Latency: target ack in cycle k gives i_ack in cycle k+1. Minimum back-to-back occupancy is 4 cycles per transaction (IDLE, BUSY, DONE, arbiter regrant).
- Pulse width: i_ack, i_err and arb_ack are single-cycle pulses, and at most one i_ack/i_err bit is set.
- Counter width: clog2(TIMEOUT+1), minimum 1. With TIMEOUT=0 the counter is unused and BUSY waits indefinitely.
- Reset mid-BUSY: immediate return to the reset values, with no ack to any initiator.

Test Plan:
- Single read, N_INIT=2: gnt=2'b10; init1 adr=0x100, we=0; target acks 2 cycles after t_stb with t_dat_r=0xDEADBEEF. Required: t_adr=0x100 one cycle after gnt; i_ack=2'b10 and i_dat_r=0xDEADBEEF for exactly 1 cycle; arb_ack coincident with i_ack.
- Write: init0 adr=0x40, dat_w=0x12345678, sel=4'b0011, we=1; target acks at once. Required: t_* match the inputs and stay stable until ack; i_ack=2'b01 for one cycle.
- Target error: t_err and t_ack asserted together. Required: i_err[idx]=1, i_ack=0, arb_ack=1, t_cyc=0 the next cycle.
- Timeout: TIMEOUT=8, target never responds. Required: i_err pulse and t_cyc deassert 8 cycles after t_stb rises; TIMEOUT=0 holds t_cyc high for 1000 cycles.
- Abort: init1 drops i_cyc in its 3rd BUSY cycle. Required: t_cyc=0, arb_ack=1, i_ack=i_err=0.
- Reset/back-to-back:
  - Alternating grants 01/10 with a real arbiter give a 4-cycle spacing, and each ack goes to the correct initiator.
  - Async reset asserted mid-BUSY clears all outputs without waiting for a clock edge.
